idct_block_stream_adapter: RTL

- Streaming front/back end for the fully parallel, fixed-latency IDCT core.
- Accepts 8x8 coefficient blocks as a serial valid/ready stream in zigzag order and de-zigzags them into a 64-entry block register.
- Drives that register into the core, waits LATENCY cycles, captures the 64 core outputs, and re-serialises them in raster order on a valid/ready output stream.
- Replaces bench-style parallel poking of the core and sits between the entropy decoder and the pixel writer.

---
 rtl/idct_block_stream_adapter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/idct_block_stream_adapter.sv
// idct_block_stream_adapter
// Streaming wrapper around a fully parallel, fixed-latency 8x8 IDCT core.
// Coefficients arrive serially in zigzag order and are de-zigzagged into an
// input buffer. A full input buffer is launched onto blk_x. LATENCY cycles
// later blk_out is captured into an output buffer. The output buffer is then
// replayed in raster order on the m_* stream.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   s_valid/s_ready/s_data coefficient input stream (zigzag order, 64 beats)
//   blk_x                  64 x W block driven to the core (raster r at [r*W +: W])
//   blk_out                64 x W block returned by the core (same packing)
//   m_valid/m_ready/m_data output pixel stream (raster order 0..63)
//   m_last                 marks raster index 63
//   busy                   any block in flight or partially/fully buffered
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | core and output buffer empty; launch as soon as IB is full
// ST_WAIT  | block in the core; lat_cnt counts down to the capture edge
// ST_DRAIN | output buffer being replayed on the m_* stream

module idct_block_stream_adapter #(
    parameter int W       = 16,
    parameter int LATENCY = 29
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [W-1:0]      s_data,
    output logic [64*W-1:0]   blk_x,
    input  logic [64*W-1:0]   blk_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [W-1:0]      m_data,
    output logic              m_last,
    output logic              busy
);

    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LW-1:0] LAT_INIT = LW'(LATENCY - 1);

    // zigzag index -> raster index
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
    logic [5:0]        zc_q, zc_d;
    logic [5:0]        rc_q, rc_d;
    logic              ib_full_q, ib_full_d;
    logic [W-1:0]      ib_q [64];
    logic [W-1:0]      ib_d [64];
    logic [W-1:0]      ob_q [64];
    logic [W-1:0]      ob_d [64];
    logic [64*W-1:0]   blk_x_q, blk_x_d;

    logic accept;
    logic drain_beat;
    logic launch;

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        zc_d      = zc_q;
        rc_d      = rc_q;
        ib_full_d = ib_full_q;
        ib_d      = ib_q;
        ob_d      = ob_q;
        blk_x_d   = blk_x_q;

        accept     = s_valid && !ib_full_q;
        drain_beat = (state_q == ST_DRAIN) && m_ready;
        // Launch needs both a full IB and an empty core/OB; the last drain
        // beat frees the OB on the same edge, giving back-to-back blocks.
        launch     = ib_full_q &&
                     ((state_q == ST_IDLE) || (drain_beat && (rc_q == 6'd63)));

        // accept and launch are mutually exclusive (!ib_full vs ib_full),
        // so a launch only ever copies a complete, earlier block.
        if (accept) begin
            ib_d[ZZ[zc_q]] = s_data;
            zc_d           = zc_q + 6'd1;
            if (zc_q == 6'd63) begin
                ib_full_d = 1'b1;
            end
        end

        case (state_q)
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    for (int r = 0; r < 64; r++) begin
                        ob_d[r] = blk_out[r*W +: W];
                    end
                    rc_d    = 6'd0;
                    state_d = ST_DRAIN;
                end else begin
                    lat_cnt_d = lat_cnt_q - LW'(1);
                end
            end
            ST_DRAIN: begin
                if (m_ready) begin
                    rc_d = rc_q + 6'd1;
                    if (rc_q == 6'd63) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: ;
        endcase

        if (launch) begin
            for (int r = 0; r < 64; r++) begin
                blk_x_d[r*W +: W] = ib_q[r];
            end
            ib_full_d = 1'b0;
            lat_cnt_d = LAT_INIT;
            state_d   = ST_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
            zc_q      <= '0;
            rc_q      <= '0;
            ib_full_q <= 1'b0;
            blk_x_q   <= '0;
            for (int i = 0; i < 64; i++) begin
                ib_q[i] <= '0;
                ob_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            zc_q      <= zc_d;
            rc_q      <= rc_d;
            ib_full_q <= ib_full_d;
            blk_x_q   <= blk_x_d;
            ib_q      <= ib_d;
            ob_q      <= ob_d;
        end
    end

    assign s_ready = !ib_full_q;
    assign m_valid = (state_q == ST_DRAIN);
    assign m_data  = m_valid ? ob_q[rc_q] : '0;
    assign m_last  = m_valid && (rc_q == 6'd63);
    // A partially assembled block (zc != 0) also counts as buffered data.
    assign busy    = (state_q != ST_IDLE) || ib_full_q || (zc_q != 6'd0);
    assign blk_x   = blk_x_q;

endmodule
